// File: rtl/cp0_irq_nest.sv
// Coprocessor-0 block with STATUS/CAUSE/EPC, a COUNT/COMPARE timer, masked level interrupts
// and a stack of saved {IE,IM} contexts so that handlers can nest up to NEST_DEPTH levels.
module cp0_irq_nest #(
  parameter int unsigned NUM_IRQ    = 6,
  parameter int unsigned NEST_DEPTH = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               read_cp0,
  input  logic               write_cp0,
  input  logic [4:0]         destination_reg,
  input  logic [31:0]        write_data,
  input  logic [31:0]        program_counter,
  input  logic               exception_signal,
  input  logic [4:0]         cause_code,
  input  logic               eret_signal,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [31:0]        read_data_out,
  output logic [31:0]        status_out,
  output logic [31:0]        exception_address_out,
  output logic               take_exc_out,
  output logic               timer_irq_out,
  output logic               nest_overflow_out
);

  localparam int unsigned   DW         = $clog2(NEST_DEPTH + 1);
  localparam int unsigned   STACK_SIZE = 1 << DW;
  localparam logic [DW-1:0] DEPTH_MAX  = DW'(NEST_DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
  localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0]        count_r;
  logic [31:0]        compare_r;
  logic [31:0]        epc_r;
  logic               ie_r;
  logic [7:0]         im_r;
  logic [4:0]         exc_code_r;
  logic               timer_r;
  logic               overflow_r;
  logic [NUM_IRQ-1:0] irq_meta_r;
  logic [NUM_IRQ-1:0] irq_sync_r;
  logic [DW-1:0]      depth_r;
  logic [8:0]         stack_r [0:STACK_SIZE-1];

  logic [7:0]  ip_s;
  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic [31:0] rd_mux_s;
  logic        int_req_s;
  logic        take_s;
  logic        stack_full_s;
  logic        wr_ok_s;
  logic        wr_count_s;
  logic        wr_compare_s;

  // Pending-interrupt vector: synchronised external levels plus the timer in IP[7].
  always_comb begin
    ip_s = 8'h00;
    ip_s[NUM_IRQ-1:0] = irq_sync_r;
    ip_s[7] = timer_r;
  end

  assign status_s     = {16'h0000, im_r, 7'h00, ie_r};
  assign cause_s      = {16'h0000, ip_s, 1'b0, exc_code_r, 2'b00};
  assign stack_full_s = (depth_r == DEPTH_MAX);

  // Arbitration: exception > ERET > interrupt > mtc0.
  always_comb begin
    int_req_s    = ie_r & (|(ip_s & im_r)) & (depth_r < DEPTH_MAX)
                   & ~exception_signal & ~eret_signal;
    take_s       = exception_signal | int_req_s;
    wr_ok_s      = write_cp0 & ~take_s & ~eret_signal;
    wr_count_s   = wr_ok_s & (destination_reg == REG_COUNT);
    wr_compare_s = wr_ok_s & (destination_reg == REG_COMPARE);
  end

  // mfc0 read mux over the current register values.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (destination_reg)
      REG_COUNT:   rd_mux_s = count_r;
      REG_COMPARE: rd_mux_s = compare_r;
      REG_STATUS:  rd_mux_s = status_s;
      REG_CAUSE:   rd_mux_s = cause_s;
      REG_EPC:     rd_mux_s = epc_r;
      default:     rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Output drive; the redirect target follows the winning event of this cycle.
  always_comb begin
    if (read_cp0) begin
      read_data_out = rd_mux_s;
    end else begin
      read_data_out = 32'h0000_0000;
    end
    if (eret_signal && !exception_signal) begin
      exception_address_out = epc_r;
    end else begin
      exception_address_out = EXC_VECTOR;
    end
    status_out        = status_s;
    take_exc_out      = take_s;
    timer_irq_out     = timer_r;
    nest_overflow_out = overflow_r;
  end

  // Two-flop synchroniser for the asynchronous interrupt levels.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      irq_meta_r <= {NUM_IRQ{1'b0}};
      irq_sync_r <= {NUM_IRQ{1'b0}};
    end else begin
      irq_meta_r <= irq_in;
      irq_sync_r <= irq_meta_r;
    end
  end

  // COUNT/COMPARE timer; a COMPARE write clears the pending flag even on a match cycle.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count_r   <= 32'h0000_0000;
      compare_r <= 32'h0000_0000;
      timer_r   <= 1'b0;
    end else begin
      if (!TIMER_EN) begin
        count_r <= 32'h0000_0000;
      end else if (wr_count_s) begin
        count_r <= write_data;
      end else begin
        count_r <= count_r + 32'd1;
      end
      if (wr_compare_s) begin
        compare_r <= write_data;
        timer_r   <= 1'b0;
      end else if (TIMER_EN && (count_r == compare_r)) begin
        compare_r <= compare_r;
        timer_r   <= 1'b1;
      end else begin
        compare_r <= compare_r;
        timer_r   <= timer_r;
      end
    end
  end

  // Exception/interrupt entry, ERET context restore and mtc0 of STATUS/CAUSE/EPC.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ie_r       <= 1'b0;
      im_r       <= 8'h00;
      epc_r      <= 32'h0000_0000;
      exc_code_r <= 5'd0;
      depth_r    <= DEPTH_ZERO;
      overflow_r <= 1'b0;
      for (int i = 0; i < STACK_SIZE; i++) begin
        stack_r[i] <= 9'h000;
      end
    end else if (take_s) begin
      epc_r      <= program_counter;
      exc_code_r <= exception_signal ? cause_code : 5'd0;
      ie_r       <= 1'b0;
      if (stack_full_s) begin
        overflow_r <= 1'b1;
      end else begin
        stack_r[depth_r] <= {ie_r, im_r};
        depth_r          <= depth_r + DEPTH_ONE;
      end
    end else if (eret_signal) begin
      if (depth_r != DEPTH_ZERO) begin
        {ie_r, im_r} <= stack_r[depth_r - DEPTH_ONE];
        depth_r      <= depth_r - DEPTH_ONE;
      end
    end else if (wr_ok_s) begin
      case (destination_reg)
        REG_STATUS: begin
          ie_r <= write_data[0];
          im_r <= write_data[15:8];
        end
        REG_CAUSE: exc_code_r <= write_data[6:2];
        REG_EPC:   epc_r      <= write_data;
        default:   epc_r      <= epc_r;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_irq_nest.sv
// Bench for cp0_irq_nest: directed scenarios plus a randomized phase, all checked every
// cycle against a queue-based reference model of the CP0 rules.
module tb_cp0_irq_nest;
  localparam int          NI  = 6;
  localparam int          ND  = 2;
  localparam logic [31:0] VEC = 32'h00400004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rd, wr, exc, eret;
  logic [4:0]    dst, cc;
  logic [31:0]   wd, pc;
  logic [NI-1:0] irq;
  logic [31:0]   rdata, status, addr;
  logic          take, tmr, ovf;

  cp0_irq_nest #(.NUM_IRQ(NI), .NEST_DEPTH(ND), .EXC_VECTOR(VEC), .TIMER_EN(1'b1)) dut (
    .clk_in(clk), .reset_in(rst), .read_cp0(rd), .write_cp0(wr),
    .destination_reg(dst), .write_data(wd), .program_counter(pc),
    .exception_signal(exc), .cause_code(cc), .eret_signal(eret), .irq_in(irq),
    .read_data_out(rdata), .status_out(status), .exception_address_out(addr),
    .take_exc_out(take), .timer_irq_out(tmr), .nest_overflow_out(ovf)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0]   m_count, m_compare, m_epc;
  logic          m_ie, m_tmr, m_ovf;
  logic [7:0]    m_im;
  logic [4:0]    m_exc;
  logic [8:0]    m_stack[$];
  logic [NI-1:0] m_sync[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_ip();
    return {m_tmr, 1'b0, m_sync[0]};
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] r);
    case (r)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0000, m_im, 7'h00, m_ie};
      5'd13:   return {16'h0000, m_ip(), 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 32'h0; m_compare = 32'h0; m_epc = 32'h0;
    m_ie = 1'b0; m_tmr = 1'b0; m_ovf = 1'b0; m_im = 8'h00; m_exc = 5'd0;
    m_stack.delete();
    m_sync.delete();
    m_sync.push_back('0);
    m_sync.push_back('0);
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance the model.
  task automatic step();
    logic ireq, tk, wok;
    logic [8:0] top;
    @(negedge clk);
    ireq = m_ie && ((m_ip() & m_im) != 8'h00) && (m_stack.size() < ND) && !exc && !eret;
    tk   = exc || ireq;
    wok  = wr && !tk && !eret;
    if (!rst) begin
      check("take", 32'(take), 32'(tk));
      check("addr", addr, (eret && !exc) ? m_epc : VEC);
      check("rdata", rdata, rd ? m_reg(dst) : 32'h0);
      check("status", status, m_reg(5'd12));
      check("timer", 32'(tmr), 32'(m_tmr));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
    if (rst) begin
      model_reset();
    end else begin
      if (wok && dst == 5'd11) m_tmr = 1'b0;
      else if (m_count == m_compare) m_tmr = 1'b1;
      if (wok && dst == 5'd9) m_count = wd;
      else m_count = m_count + 32'd1;
      m_sync.push_back(irq);
      void'(m_sync.pop_front());
      if (tk) begin
        m_epc = pc;
        m_exc = exc ? cc : 5'd0;
        if (m_stack.size() < ND) m_stack.push_back({m_ie, m_im});
        else m_ovf = 1'b1;
        m_ie = 1'b0;
      end else if (eret) begin
        if (m_stack.size() > 0) begin
          top = m_stack.pop_back();
          m_ie = top[8];
          m_im = top[7:0];
        end
      end else if (wok) begin
        case (dst)
          5'd11: m_compare = wd;
          5'd12: begin m_ie = wd[0]; m_im = wd[15:8]; end
          5'd13: m_exc = wd[6:2];
          5'd14: m_epc = wd;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rd = 1'b0; wr = 1'b0; exc = 1'b0; eret = 1'b0;
    dst = 5'd0; cc = 5'd0; wd = 32'h0; pc = 32'h0; irq = '0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    wr = 1'b1; dst = r; wd = d;
    step();
    wr = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic syscall(input logic [31:0] p);
    exc = 1'b1; cc = 5'd8; pc = p;
    step();
    exc = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
    rd = 1'b1; dst = r;
    #1;
    check(tag, rdata, exp);
    rd = 1'b0;
  endtask

  logic [4:0] dsts [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
  logic [31:0] tmp;

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // reset state
    read_chk("rst_cause", 5'd13, 32'h0);
    read_chk("rst_status", 5'd12, 32'h0);
    read_chk("rst_epc", 5'd14, 32'h0);
    check("rst_addr", addr, 32'h00400004);
    check("rst_take", 32'(take), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    step();

    // external interrupt with 2-cycle synchroniser latency
    mtc0(5'd12, 32'h0000_0101);
    irq = 6'b000001; pc = 32'h00400100;
    #1; check("irq_lat0", 32'(take), 32'h0);
    step();
    check("irq_lat1", 32'(take), 32'h0);
    step();
    check("irq_take", 32'(take), 32'h1);
    step();
    irq = '0;
    read_chk("irq_epc", 5'd14, 32'h00400100);
    read_chk("irq_status", 5'd12, 32'h0000_0100);
    rd = 1'b1; dst = 5'd13; #1;
    tmp = rdata & 32'h0000_007C;
    check("irq_exccode", tmp, 32'h0);
    rd = 1'b0;
    repeat (3) step();
    do_eret();
    check("eret_pop", status, 32'h0000_0101);
    mtc0(5'd12, 32'h0000_0201);
    do_eret();
    check("eret_empty", status, 32'h0000_0201);
    mtc0(5'd12, 32'h0);

    // timer: COMPARE=20, COUNT=15
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd15);
    for (int i = 1; i <= 7; i++) begin
      rd = 1'b1; dst = 5'd9; #1;
      check("tmr_count", rdata, 32'd15 + 32'(i) - 32'd1);
      check("tmr_pend", 32'(tmr), (i == 7) ? 32'h1 : 32'h0);
      step();
    end
    rd = 1'b0;
    mtc0(5'd11, 32'd0);
    check("tmr_clear", 32'(tmr), 32'h0);

    // exception + ERET + irq + mtc0 in one cycle
    mtc0(5'd12, 32'h0000_0301);
    irq = 6'b000010;
    repeat (3) step();
    irq = 6'b000010; exc = 1'b1; cc = 5'd8; eret = 1'b1;
    wr = 1'b1; dst = 5'd12; wd = 32'h0000_FFFF; pc = 32'h00400200;
    #1; check("prio_take", 32'(take), 32'h1);
    check("prio_addr", addr, VEC);
    step();
    idle();
    check("prio_status", status, 32'h0000_0300);
    read_chk("prio_epc", 5'd14, 32'h00400200);
    rd = 1'b1; dst = 5'd13; #1;
    tmp = rdata & 32'h0000_007C;
    check("prio_exccode", tmp, 32'h0000_0020);
    rd = 1'b0;
    repeat (3) step();
    do_eret();
    check("prio_pop1", status, 32'h0000_0300);
    do_eret();
    check("prio_pop2", status, 32'h0000_0301);
    mtc0(5'd12, 32'h0);

    // nesting overflow at depth 2
    check("ovf_before", 32'(ovf), 32'h0);
    mtc0(5'd12, 32'h0000_0501);
    syscall(32'h00400300);
    mtc0(5'd12, 32'h0000_0A01);
    syscall(32'h00400304);
    check("ovf_not_yet", 32'(ovf), 32'h0);
    mtc0(5'd12, 32'h0000_0F01);
    syscall(32'h00400308);
    check("ovf_set", 32'(ovf), 32'h1);
    do_eret();
    check("ovf_pop2", status, 32'h0000_0A01);
    do_eret();
    check("ovf_pop1", status, 32'h0000_0501);
    do_eret();
    check("ovf_pop0", status, 32'h0000_0501);

    // masked interrupts and COUNT wrap
    mtc0(5'd12, 32'h0000_0001);
    irq = '1;
    for (int i = 0; i < 4; i++) begin
      #1; check("mask_take", 32'(take), 32'h0);
      step();
    end
    irq = '0;
    mtc0(5'd9, 32'hFFFF_FFFF);
    read_chk("wrap_hi", 5'd9, 32'hFFFF_FFFF);
    step();
    read_chk("wrap_lo", 5'd9, 32'h0);
    mtc0(5'd12, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      exc = (r < 4);
      eret = (r >= 4 && r < 14);
      cc = 5'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      dst = dsts[$urandom_range(0, 5)];
      wd = $urandom;
      if (dst == 5'd9) wd = m_compare - 32'($urandom_range(0, 6));
      rd = 1'($urandom);
      irq = NI'($urandom);
      pc = $urandom;
      step();
    end
    idle();

    // reset in the middle of a handler
    mtc0(5'd12, 32'h0000_0101);
    irq = 6'b000001;
    repeat (3) step();
    irq = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_status", status, 32'h0);
    check("rst_mid_ovf", 32'(ovf), 32'h0);
    repeat (3) step();
    do_eret();
    check("rst_mid_eret", status, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
